uart_rx_byte: RTL
=================

# uart_rx_byte

UART receive front end that deserialises the asynchronous `UART_RXD` pin into bytes for the serial echo/buffer stage downstream. It synchronises the pin into the `i_Clk` domain and detects start bits. Each bit is recovered by a 3-sample majority vote at mid-bit, and stop bits are checked. The block emits one-cycle valid pulses with stable data, which are the byte events the downstream stage counts, buffers and shows on `LEDR`/`HEX`. 8N1 format, LSB first, fixed baud set by parameter.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Legal range ≥ 8.
- `i_Clk` in 1: system clock (`CLOCK_50`).
- `i_Rst_n` in 1: asynchronous, active-low reset (`KEY[0]`).
- `i_UART_RXD` in 1: raw serial line, asynchronous to `i_Clk`, idle high.
- `o_rx_data` out 8: last correctly framed byte. Held until the next valid byte.
- `o_rx_valid` out 1: one-cycle pulse; `o_rx_data` is new this cycle.
- `o_frame_err` out 1: one-cycle pulse; the stop bit was sampled low.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
- **Synchroniser.** 2-FF synchroniser on `i_UART_RXD` produces `rxd_s`. Both FFs reset to 0, so the line must be seen high after reset before any frame is accepted.
- **Derived constants.** HALF = CLKS_PER_BIT/2 (integer). `clk_cnt` width is ceil(log2(CLKS_PER_BIT)). `bit_idx` is 3 bits.
- **Majority vote.** A bit decision is majority(3) of `rxd_s` at the decision count and the two cycles before it.
- **WAIT_IDLE** (reset state): stay until `rxd_s`==1, then go to IDLE.
- **IDLE:** on `rxd_s`==0, go to START and set `clk_cnt`=0.
- **START:** `clk_cnt` increments each cycle. Decision at `clk_cnt`==HALF, using samples at HALF-2..HALF:
  - Vote 1: false start, return to IDLE. No output.
  - Vote 0: go to DATA with `clk_cnt`=0 and `bit_idx`=0.
- **DATA:** decision at `clk_cnt`==CLKS_PER_BIT-1, using samples at CLKS_PER_BIT-3..CLKS_PER_BIT-1.
  - Shift the vote into shift-register bit `bit_idx` (LSB first) and set `clk_cnt`=0.
  - After `bit_idx`==7, go to STOP. Otherwise increment `bit_idx`.
- **STOP:** decision at `clk_cnt`==CLKS_PER_BIT-1.
  - Vote 1: load `o_rx_data` from the shift register, pulse `o_rx_valid` the next cycle, go to IDLE.
  - Vote 0: pulse `o_frame_err` the next cycle, leave `o_rx_data` unchanged, go to WAIT_IDLE. A break condition therefore yields exactly one `o_frame_err`.
- **Early return for resync.** IDLE is re-entered at stop-bit centre, not at the end of the stop bit. A start edge arriving half a bit later is accepted.
- **Reset.** Asynchronous reset at any time, including mid-frame, aborts the frame:
  - State WAIT_IDLE.
  - `o_rx_data`=0x00, `o_rx_valid`=0, `o_frame_err`=0, `o_busy`=1 (WAIT_IDLE counts as busy).
  - Counters and shift register cleared.
- **Exclusive pulses.** `o_rx_valid` and `o_frame_err` are never high in the same cycle.

## Timing
- **Latency.** `o_rx_valid` asserts HALF + 9·CLKS_PER_BIT + L cycles after the RXD falling edge, where 3 ≤ L ≤ 5 (synchroniser plus registered output).
- **Pulse width.** `o_rx_valid` and `o_frame_err` are exactly 1 cycle. No handshake; the downstream stage must accept them every cycle.
- **Data hold.** `o_rx_data` changes only in the cycle `o_rx_valid` is high.
- **Back-to-back frames.** Frames with one stop bit and zero idle are received without loss. Minimum spacing between two `o_rx_valid` pulses is 10·CLKS_PER_BIT − HALF − 2.
- **Baud tolerance.** Sender baud error of ±2% must still decode correctly.

## Test plan
All scenarios use CLKS_PER_BIT=16 for simulation; one regression repeats them at 434.
- **Single byte.** Send 0x55, then idle high → one `o_rx_valid` at 8 + 144 + L cycles. `o_rx_data`=0x55. `o_frame_err` never high.
- **Back-to-back.** Send 0x00, 0xFF, 0xA3 with no idle gap → three valid pulses carrying 0x00, 0xFF, 0xA3 in order. Data stable between pulses.
- **Glitch.** Line low for 5 cycles, then high → no valid or error pulse. `o_busy` falls back to 0 within HALF+3 cycles. A following 0x3C frame is received correctly.
- **Framing error.** 0x41 with stop bit driven low, then line held low 40 cycles, then high → one `o_frame_err` pulse. `o_rx_data` keeps its prior value. A following 0x42 frame is received as 0x42.
- **Reset mid-frame.** `i_Rst_n` low during data bit 4 of 0x99 → outputs immediately reset to their reset values. After release, with the line held high ≥3 cycles, 0x7E is received correctly and no spurious pulse occurs.
- **Baud error.** Sender bit period of 16 ±2% (bit widths dithered 15/16/17) over 256 random bytes → all decoded correctly with zero `o_frame_err`.

Source files
------------

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with 2-FF synchroniser and 3-sample majority vote
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_UART_RXD,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state, state_nxt;
    logic             sync1, rxd_s, hist1, hist2, vote;
    logic [CNT_W-1:0] clk_cnt, cnt_nxt;
    logic [2:0]       bit_idx, idx_nxt;
    logic [7:0]       shreg, sh_nxt;
    logic             load, valid_nxt, err_nxt;

    // hist1/hist2 hold rxd_s from the previous two cycles, so the vote spans count-2..count
    assign vote   = (rxd_s & hist1) | (rxd_s & hist2) | (hist1 & hist2);
    assign o_busy = (state != S_IDLE);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1       <= 1'b0;
            rxd_s       <= 1'b0;
            hist1       <= 1'b0;
            hist2       <= 1'b0;
            state       <= S_WAIT_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            sync1       <= i_UART_RXD;
            rxd_s       <= sync1;
            hist1       <= rxd_s;
            hist2       <= hist1;
            state       <= state_nxt;
            clk_cnt     <= cnt_nxt;
            bit_idx     <= idx_nxt;
            shreg       <= sh_nxt;
            o_rx_valid  <= valid_nxt;
            o_frame_err <= err_nxt;
            if (load) begin
                o_rx_data <= shreg;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = clk_cnt;
        idx_nxt   = bit_idx;
        sh_nxt    = shreg;
        load      = 1'b0;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            S_WAIT_IDLE: begin
                if (rxd_s) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!rxd_s) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (clk_cnt == CNT_HALF) begin
                    cnt_nxt = '0;
                    idx_nxt = '0;
                    state_nxt = vote ? S_IDLE : S_DATA;
                end else begin
                    cnt_nxt = clk_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    cnt_nxt         = '0;
                    sh_nxt[bit_idx] = vote;
                    if (bit_idx == 3'd7) state_nxt = S_STOP;
                    else                 idx_nxt   = bit_idx + 3'd1;
                end else begin
                    cnt_nxt = clk_cnt + CNT_ONE;
                end
            end
            S_STOP: begin
                // Leave at stop-bit centre so a start edge half a bit later is still caught
                if (clk_cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (vote) begin
                        load      = 1'b1;
                        valid_nxt = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_nxt = clk_cnt + CNT_ONE;
                end
            end
            default: state_nxt = S_WAIT_IDLE;
        endcase
    end

endmodule
